// File: rtl/instr_sequencer.sv
// Instruction sequencer: queues 16-bit instruction words and issues them one at a
// time to a CPU using a load/start handshake, then captures the result and flags.
//
// state     | meaning
// IDLE      | waiting for go
// LOAD      | head word on cpu_in, cpu_load asserted
// START     | cpu_load and cpu_s asserted, head popped on exit
// WAIT_BUSY | waiting for cpu_w to fall, timer running
// WAIT_DONE | waiting for cpu_w to rise, then capture result
module instr_sequencer #(
  parameter int DEPTH        = 8,
  parameter int WAIT_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  logic [15:0] push_data,
  output logic        full,
  input  logic        go,
  output logic        cpu_load,
  output logic        cpu_s,
  output logic [15:0] cpu_in,
  input  logic        cpu_w,
  input  logic [15:0] cpu_out,
  input  logic [2:0]  cpu_flags,
  output logic [15:0] result,
  output logic [2:0]  result_flags,
  output logic        done,
  output logic        busy,
  output logic [7:0]  issued,
  output logic        timeout_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(WAIT_TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT_BUSY, WAIT_DONE} state_t;

  state_t          state, state_nxt;
  logic [15:0]     mem [DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic [TW-1:0]   timer;
  logic            empty, push_ok, pop, flush, complete, done_nxt;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign push_ok = push && !full;
  assign busy    = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    flush     = 1'b0;
    complete  = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (go) begin
          if (!empty) state_nxt = LOAD;
          else        done_nxt  = 1'b1;
        end
      end
      LOAD: state_nxt = START;
      START: begin
        pop       = 1'b1;
        state_nxt = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (!cpu_w) begin
          state_nxt = WAIT_DONE;
        end else if (timer == TW'(WAIT_TIMEOUT - 1)) begin
          // CPU never acknowledged the start: drop the rest of the program
          flush     = 1'b1;
          state_nxt = IDLE;
        end
      end
      WAIT_DONE: begin
        if (cpu_w) begin
          complete = 1'b1;
          if (!empty) begin
            state_nxt = LOAD;
          end else begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (flush) begin
        // a word pushed in the flush cycle sits at wr_ptr and survives
        rd_ptr <= wr_ptr;
        count  <= push_ok ? CW'(1) : '0;
      end else begin
        if (pop) rd_ptr <= rd_ptr + PW'(1);
        count <= count + CW'(push_ok) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer <= '0;
    end else if (state == START) begin
      timer <= '0;
    end else if (state == WAIT_BUSY && timer != TW'(WAIT_TIMEOUT)) begin
      timer <= timer + TW'(1);
    end
  end

  // CPU-side outputs are registered from the next state so they line up with it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpu_load <= 1'b0;
      cpu_s    <= 1'b0;
      cpu_in   <= '0;
    end else begin
      cpu_load <= (state_nxt == LOAD) || (state_nxt == START);
      cpu_s    <= (state_nxt == START);
      cpu_in   <= ((state_nxt == LOAD) || (state_nxt == START)) ? mem[rd_ptr] : 16'h0000;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result       <= '0;
      result_flags <= '0;
      issued       <= '0;
      done         <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      done <= done_nxt;
      if (complete) begin
        result       <= cpu_out;
        result_flags <= cpu_flags;
        issued       <= issued + 8'd1;
      end
      if (flush) timeout_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: the bench plays the CPU and checks issue
// order, handshake timing, captures, timeout, reset and counter wrap.
module tb_instr_sequencer;

  localparam int DEPTH = 8;
  localparam int WT    = 15;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        push = 1'b0;
  logic [15:0] push_data = '0;
  logic        go = 1'b0;
  logic        cpu_w = 1'b1;
  logic [15:0] cpu_out = '0;
  logic [2:0]  cpu_flags = '0;
  logic        full, cpu_load, cpu_s, done, busy, timeout_err;
  logic [15:0] cpu_in, result;
  logic [2:0]  result_flags;
  logic [7:0]  issued;

  int          checks = 0;
  int          errors = 0;
  int          done_cnt = 0;
  int          act_cnt = 0;
  logic [7:0]  exp_issued = '0;
  logic [15:0] mq[$];

  instr_sequencer #(.DEPTH(DEPTH), .WAIT_TIMEOUT(WT)) dut (
    .clk(clk), .reset(reset), .push(push), .push_data(push_data), .full(full),
    .go(go), .cpu_load(cpu_load), .cpu_s(cpu_s), .cpu_in(cpu_in), .cpu_w(cpu_w),
    .cpu_out(cpu_out), .cpu_flags(cpu_flags), .result(result),
    .result_flags(result_flags), .done(done), .busy(busy), .issued(issued),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (cpu_load === 1'b1 || cpu_s === 1'b1) act_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [15:0] w);
    push = 1'b1;
    push_data = w;
    step();
    push = 1'b0;
    if (mq.size() < DEPTH) mq.push_back(w);
  endtask

  task automatic pulse_go();
    go = 1'b1;
    step();
    go = 1'b0;
  endtask

  // One full CPU transaction; optional push during START or during WAIT_DONE.
  task automatic issue(input logic [15:0] res, input logic [2:0] fl, input int hold,
                       input bit start_push, input bit wd_push, input logic [15:0] pw);
    logic [15:0] w;
    int n;
    n = 0;
    while (cpu_load !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk("load_seen", cpu_load, 1);
    w = (mq.size() > 0) ? mq[0] : 16'hDEAD;
    chk("load_no_s", cpu_s, 0);
    chk("load_word", cpu_in, w);
    step();
    chk("start_s", cpu_s, 1);
    chk("start_load", cpu_load, 1);
    chk("start_word", cpu_in, w);
    if (start_push) begin
      push = 1'b1;
      push_data = pw;
      if (mq.size() < DEPTH) mq.push_back(pw);
    end
    if (mq.size() > 0) mq.delete(0);
    cpu_w = 1'b0;
    step();
    push = 1'b0;
    if (start_push) chk("push_pop_full", full, 0);
    chk("wb_handshake", {cpu_load, cpu_s}, 0);
    chk("wb_word", cpu_in, 0);
    repeat (hold) step();
    if (wd_push) begin
      push = 1'b1;
      push_data = pw;
      step();
      push = 1'b0;
      if (mq.size() < DEPTH) mq.push_back(pw);
    end
    cpu_out = res;
    cpu_flags = fl;
    cpu_w = 1'b1;
    step();
    exp_issued = exp_issued + 8'd1;
    chk("cap_result", result, res);
    chk("cap_flags", result_flags, fl);
    chk("cap_issued", issued, exp_issued);
  endtask

  initial begin
    int d0;
    int a0;

    step();
    step();
    chk("rst_ctrl", {cpu_load, cpu_s, done, busy, full, timeout_err}, 0);
    chk("rst_issued", issued, 0);
    chk("rst_result", result, 0);
    chk("rst_flags", result_flags, 0);
    chk("rst_cpu_in", cpu_in, 0);
    reset = 1'b0;
    step();

    // four-instruction program
    push_word(16'hD501);
    push_word(16'hD602);
    push_word(16'hA506);
    push_word(16'hAD16);
    d0 = done_cnt;
    pulse_go();
    chk("go_latency_load", cpu_load, 1);
    chk("go_latency_s", cpu_s, 0);
    issue(16'd1, 3'b000, 1, 0, 0, 16'h0);
    issue(16'd2, 3'b000, 2, 0, 0, 16'h0);
    issue(16'd3, 3'b000, 1, 0, 0, 16'h0);
    issue(16'd3, 3'b001, 3, 0, 0, 16'h0);
    chk("prog_done", done, 1);
    chk("prog_issued", issued, 4);
    chk("prog_result", result, 16'd3);
    chk("prog_flags", result_flags, 3'b001);
    step();
    chk("prog_done_clr", done, 0);
    chk("prog_busy", busy, 0);
    chk("prog_done_cnt", done_cnt - d0, 1);

    // go with an empty queue
    a0 = act_cnt;
    d0 = done_cnt;
    pulse_go();
    chk("empty_done", done, 1);
    chk("empty_busy", busy, 0);
    step();
    chk("empty_done_clr", done, 0);
    repeat (3) step();
    chk("empty_no_cpu", act_cnt - a0, 0);
    chk("empty_issued", issued, 4);
    chk("empty_done_cnt", done_cnt - d0, 1);

    // overfill: the ninth word must be dropped
    for (int i = 0; i < DEPTH + 1; i++) begin
      push_word(16'h1000 + 16'(i));
      if (i == DEPTH - 2) chk("fill_not_full", full, 0);
      if (i == DEPTH - 1) chk("fill_full", full, 1);
    end
    chk("fill_still_full", full, 1);
    d0 = done_cnt;
    pulse_go();
    for (int i = 0; i < DEPTH; i++) issue(16'h0100 + 16'(i), 3'(i), 1 + (i % 2), 0, 0, 16'h0);
    chk("fill_last_result", result, 16'h0107);
    chk("fill_done", done, 1);
    a0 = act_cnt;
    repeat (4) step();
    chk("fill_no_extra", act_cnt - a0, 0);
    chk("fill_issued", issued, 12);
    chk("fill_done_cnt", done_cnt - d0, 1);
    chk("fill_empty", full, 0);

    // CPU never drops cpu_w
    push_word(16'hBEEF);
    push_word(16'hCAFE);
    d0 = done_cnt;
    pulse_go();
    chk("to_load", cpu_load, 1);
    chk("to_word", cpu_in, 16'hBEEF);
    step();
    chk("to_start", cpu_s, 1);
    step();
    repeat (WT - 1) step();
    chk("to_pre_err", timeout_err, 0);
    chk("to_pre_busy", busy, 1);
    step();
    chk("to_err", timeout_err, 1);
    chk("to_busy", busy, 0);
    mq.delete();
    step();
    chk("to_no_done", done_cnt - d0, 0);
    a0 = act_cnt;
    pulse_go();
    chk("to_flush_done", done, 1);
    repeat (3) step();
    chk("to_flush_idle", act_cnt - a0, 0);
    push_word(16'h5A5A);
    pulse_go();
    issue(16'h0077, 3'b100, 1, 0, 0, 16'h0);
    chk("to_recover_done", done, 1);
    chk("to_sticky", timeout_err, 1);
    chk("to_issued", issued, 13);

    // reset in WAIT_DONE of the second of three
    push_word(16'h3001);
    push_word(16'h3002);
    push_word(16'h3003);
    pulse_go();
    issue(16'h0011, 3'b010, 1, 0, 0, 16'h0);
    chk("rst2_load", cpu_load, 1);
    step();
    chk("rst2_start", cpu_s, 1);
    cpu_w = 1'b0;
    step();
    step();
    chk("rst2_busy", busy, 1);
    reset = 1'b1;
    #1;
    chk("rst2_ctrl", {cpu_load, cpu_s, done, busy, full, timeout_err}, 0);
    chk("rst2_issued", issued, 0);
    chk("rst2_result", result, 0);
    chk("rst2_flags", result_flags, 0);
    chk("rst2_cpu_in", cpu_in, 0);
    cpu_out = 16'hFFFF;
    cpu_w = 1'b1;
    step();
    reset = 1'b0;
    mq.delete();
    exp_issued = '0;
    step();
    chk("rst2_no_capture", result, 0);
    a0 = act_cnt;
    pulse_go();
    chk("rst2_empty_done", done, 1);
    repeat (3) step();
    chk("rst2_no_cpu", act_cnt - a0, 0);
    chk("rst2_issued_hold", issued, 0);

    // 248 completions, first run also pushes during START
    for (int r = 0; r < 31; r++) begin
      for (int i = 0; i < ((r == 0) ? 7 : 8); i++) push_word(16'h2000 + 16'(r * 8 + i));
      pulse_go();
      for (int i = 0; i < 8; i++)
        issue(16'(r * 8 + i), 3'(i), 1, (r == 0 && i == 0), 0, 16'hE000);
      chk("wrap_run_done", done, 1);
    end
    chk("wrap_mid_issued", issued, 248);

    // last run: a push in WAIT_DONE of the last entry joins the same run
    for (int i = 0; i < 8; i++) push_word(16'h4000 + 16'(i));
    d0 = done_cnt;
    pulse_go();
    for (int i = 0; i < 7; i++) issue(16'h0040 + 16'(i), 3'b000, 1, 0, 0, 16'h0);
    issue(16'h0047, 3'b000, 1, 0, 1, 16'hF00D);
    chk("wd_no_done", done, 0);
    chk("wd_reload", cpu_load, 1);
    chk("wd_word", cpu_in, 16'hF00D);
    issue(16'h0AAA, 3'b110, 2, 0, 0, 16'h0);
    chk("wd_done", done, 1);
    chk("wrap_issued", issued, 8'd1);
    chk("wd_result", result, 16'h0AAA);
    step();
    chk("wd_done_cnt", done_cnt - d0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
